// File: rtl/train_phase_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | train_phase_timer: loads the selected phase duration on a controller     |
// | state change and counts it down on prescaler ticks.  Rev 1.0             |
// +--------------------------------------------------------------------------+
module train_phase_timer #(
  parameter int WIDTH = 19,
  parameter int SW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tin,
  input  logic [SW-1:0]    present_state,
  input  logic             tick_en,
  input  logic             abort,
  output logic [WIDTH-1:0] tcount,
  output logic             busy,
  output logic             done,
  output logic             expired
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_EXPIRED = 2'd2;

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [SW-1:0]    prev_state_q, prev_state_d;
  logic [WIDTH-1:0] tcount_q, tcount_d;
  logic             done_q, done_d;
  logic             expired_q, expired_d;
  logic             w_load_req;

  assign w_load_req = (present_state != prev_state_q);

  always_comb begin
    state_d      = state_q;
    tcount_d     = tcount_q;
    expired_d    = expired_q;
    done_d       = 1'b0;
    prev_state_d = present_state;

    if (abort) begin
      // Cancel wins over a same-cycle load; prev_state still tracks so the load is lost.
      state_d   = ST_IDLE;
      tcount_d  = '0;
      expired_d = 1'b0;
    end else if (w_load_req) begin
      expired_d = 1'b0;
      tcount_d  = tin;
      state_d   = (tin != '0) ? ST_RUN : ST_IDLE;
    end else if (state_q == ST_RUN && tick_en) begin
      if (tcount_q > C_ONE) begin
        tcount_d = tcount_q - C_ONE;
      end else begin
        tcount_d  = '0;
        state_d   = ST_EXPIRED;
        done_d    = 1'b1;
        expired_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      prev_state_q <= '0;
      tcount_q     <= '0;
      done_q       <= 1'b0;
      expired_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_state_q <= prev_state_d;
      tcount_q     <= tcount_d;
      done_q       <= done_d;
      expired_q    <= expired_d;
    end
  end

  assign tcount  = tcount_q;
  assign busy    = (state_q == ST_RUN);
  assign done    = done_q;
  assign expired = expired_q;

endmodule
`default_nettype wire

// File: tb/tb_train_phase_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_train_phase_timer: directed and randomized checks of the phase timer  |
// | against a behavioural model.  Rev 1.0                                    |
// +--------------------------------------------------------------------------+
module tb_train_phase_timer;

  localparam int WIDTH = 19;
  localparam int SW    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] tin = '0;
  logic [SW-1:0]    present_state = '0;
  logic             tick_en = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] tcount;
  logic             busy;
  logic             done;
  logic             expired;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: remaining ticks plus running/expired flags.
  int          m_cnt;
  bit          m_run;
  bit          m_exp;
  bit          m_done;
  logic [SW-1:0] m_prev;
  int          done_seen;

  train_phase_timer #(.WIDTH(WIDTH), .SW(SW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tin           (tin),
    .present_state (present_state),
    .tick_en       (tick_en),
    .abort         (abort),
    .tcount        (tcount),
    .busy          (busy),
    .done          (done),
    .expired       (expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_run  = 0;
    m_exp  = 0;
    m_done = 0;
    m_prev = '0;
  endtask

  task automatic model_edge();
    bit ld;
    ld     = (present_state != m_prev);
    m_prev = present_state;
    m_done = 0;
    if (abort) begin
      m_cnt = 0; m_run = 0; m_exp = 0;
    end else if (ld) begin
      m_cnt = int'(tin); m_run = (tin != 0); m_exp = 0;
    end else if (m_run && tick_en) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_run = 0; m_exp = 1; m_done = 1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".tcount"}, 32'(tcount), 32'(m_cnt));
    chk({tag, ".busy"}, 32'(busy), 32'(m_run));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".expired"}, 32'(expired), 32'(m_exp));
  endtask

  // One clock: inputs are already set; model advances at the edge, outputs sampled 1ns later.
  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    if (done) done_seen++;
    compare_all(tag);
  endtask

  initial begin
    model_reset();
    done_seen = 0;
    #3;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cyc("idle");

    // Long load with tick every cycle.
    tin = 19'd4096; present_state = 4'd2; tick_en = 1'b1;
    cyc("load4096");
    chk("load4096.value", 32'(tcount), 32'd4096);
    done_seen = 0;
    for (int i = 0; i < 4096; i++) begin
      tin = 19'($urandom_range(0, 100));
      cyc("run4096");
    end
    chk("run4096.done_once", 32'(done_seen), 32'd1);
    chk("run4096.expired", 32'(expired), 32'd1);
    for (int i = 0; i < 3; i++) cyc("expired_hold");

    // Load 5 with a strobe every third cycle.
    tick_en = 1'b0; tin = 19'd5; present_state = 4'd3;
    cyc("load5");
    done_seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick_en = (i % 3 == 2);
      cyc("strobe3");
    end
    chk("strobe3.done_once", 32'(done_seen), 32'd1);
    tick_en = 1'b0;

    // Reload mid-run with tick high: the tick is ignored.
    tin = 19'd20; present_state = 4'd4; tick_en = 1'b1;
    cyc("load20");
    present_state = 4'd3;
    cyc("load20b");
    for (int i = 0; i < 20 && m_cnt > 10; i++) cyc("down_to10");
    chk("pre_reload.value", 32'(tcount), 32'd10);
    tin = 19'd7; present_state = 4'd4;
    cyc("reload");
    chk("reload.value", 32'(tcount), 32'd7);
    chk("reload.busy", 32'(busy), 32'd1);

    // Abort with a simultaneous state change drops the load.
    abort = 1'b1; tin = 19'd9; present_state = 4'd6;
    cyc("abort");
    chk("abort.tcount", 32'(tcount), 32'd0);
    abort = 1'b0;
    cyc("after_abort");
    present_state = 4'd7;
    cyc("load_after_abort");
    chk("load_after_abort.value", 32'(tcount), 32'd9);

    // Zero load returns to idle; full-scale load does not truncate.
    tin = 19'd0; present_state = 4'd8;
    cyc("zero_load");
    tin = 19'h7FFFF; present_state = 4'd9; tick_en = 1'b0;
    cyc("max_load");
    chk("max_load.value", 32'(tcount), 32'd524287);
    tick_en = 1'b1;
    cyc("max_tick");
    chk("max_tick.value", 32'(tcount), 32'd524286);

    // Asynchronous reset off the clock edge, then load at the first edge.
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_reset");
    tin = 19'd3; present_state = 4'd5;
    #2;
    rst_n = 1'b1;
    cyc("post_reset_load");
    chk("post_reset_load.value", 32'(tcount), 32'd3);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      tick_en = ($urandom_range(0, 1) == 1);
      abort   = ($urandom_range(0, 63) == 0);
      tin     = ($urandom_range(0, 31) == 0) ? 19'($urandom) : 19'($urandom_range(0, 12));
      if ($urandom_range(0, 15) == 0) present_state = 4'($urandom);
      cyc("random");
    end
    abort = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
